trap_sequencer: RTL and testbench

TRAP_SEQUENCER -- requirements
Module: trap_sequencer

---
 rtl/trap_sequencer.sv | 197 +++++++++++++++++++
 tb/tb_trap_sequencer.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/trap_sequencer.sv
`default_nettype none
// trap_sequencer: sequences traps and MRET through flush, machine-CSR update and PC redirect.
// Optional macro TRAP_VECTORED_EN: interrupts vector to MTVEC_BASE + 4*MCAUSE[4:0].
module trap_sequencer #(
  parameter logic [31:0] MTVEC_BASE    = 32'h0000_0100,
  parameter int unsigned FLUSH_TIMEOUT = 8
) (
  input  logic        CLK,
  input  logic        RSTn,
  input  logic        EN,
  input  logic        ILLEGAL_INSTR_i,
  input  logic        ECALL_i,
  input  logic        EXT_IRQ_i,
  input  logic        MRET_i,
  input  logic [31:0] TRAP_PC_i,
  input  logic [31:0] TRAP_INSTR_i,
  input  logic        FLUSH_ACK_i,
  output logic        STALL_o,
  output logic        FLUSH_o,
  output logic        PC_REDIRECT_o,
  output logic [31:0] PC_TARGET_o,
  output logic [31:0] MEPC_o,
  output logic [31:0] MCAUSE_o,
  output logic [31:0] MTVAL_o,
  output logic        MIE_o,
  output logic        BUSY_o
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FLUSH    = 3'd1,
    S_SAVE     = 3'd2,
    S_RESTORE  = 3'd3,
    S_REDIRECT = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    REQ_NONE  = 3'd0,
    REQ_IRQ   = 3'd1,
    REQ_ILL   = 3'd2,
    REQ_ECALL = 3'd3,
    REQ_MRET  = 3'd4
  } req_t;

  localparam int unsigned      CNT_W    = (FLUSH_TIMEOUT > 2) ? $clog2(FLUSH_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FLUSH_TIMEOUT - 1);
  localparam logic [31:0]      BASE     = MTVEC_BASE & 32'hFFFF_FFFC;

  state_t           state_q, state_d;
  req_t             kind_q, kind_d;
  req_t             req_win;
  logic             pend_q, pend_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      instr_q, instr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      mepc_q, mepc_d;
  logic [31:0]      mcause_q, mcause_d;
  logic [31:0]      mtval_q, mtval_d;
  logic             mie_q, mie_d;
  logic             mpie_q, mpie_d;

  always_comb begin
    req_win = REQ_NONE;
    if (EXT_IRQ_i && mie_q) begin
      req_win = REQ_IRQ;
    end else if (ILLEGAL_INSTR_i) begin
      req_win = REQ_ILL;
    end else if (ECALL_i) begin
      req_win = REQ_ECALL;
    end else if (MRET_i) begin
      req_win = REQ_MRET;
    end
  end

  always_comb begin
    state_d  = state_q;
    kind_d   = kind_q;
    pend_d   = pend_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    cnt_d    = cnt_q;
    mepc_d   = mepc_q;
    mcause_d = mcause_q;
    mtval_d  = mtval_q;
    mie_d    = mie_q;
    mpie_d   = mpie_q;

    case (state_q)
      S_IDLE: begin
        // Accept latches the winner; the FSM leaves IDLE one cycle later.
        if (pend_q) begin
          pend_d  = 1'b0;
          cnt_d   = '0;
          state_d = S_FLUSH;
        end else if (EN && (req_win != REQ_NONE)) begin
          pend_d  = 1'b1;
          kind_d  = req_win;
          pc_d    = TRAP_PC_i;
          instr_d = TRAP_INSTR_i;
        end
      end
      S_FLUSH: begin
        if (FLUSH_ACK_i || (cnt_q == CNT_LAST)) begin
          state_d = (kind_q == REQ_MRET) ? S_RESTORE : S_SAVE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_SAVE: begin
        mepc_d = pc_q & 32'hFFFF_FFFC;
        mpie_d = mie_q;
        mie_d  = 1'b0;
        case (kind_q)
          REQ_IRQ: begin
            mcause_d = 32'h8000_000B;
            mtval_d  = '0;
          end
          REQ_ILL: begin
            mcause_d = 32'd2;
            mtval_d  = instr_q;
          end
          default: begin
            mcause_d = 32'd11;
            mtval_d  = '0;
          end
        endcase
        state_d = S_REDIRECT;
      end
      S_RESTORE: begin
        mie_d   = mpie_q;
        mpie_d  = 1'b1;
        state_d = S_REDIRECT;
      end
      S_REDIRECT: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q  <= S_IDLE;
      kind_q   <= REQ_NONE;
      pend_q   <= 1'b0;
      pc_q     <= '0;
      instr_q  <= '0;
      cnt_q    <= '0;
      mepc_q   <= '0;
      mcause_q <= '0;
      mtval_q  <= '0;
      mie_q    <= 1'b0;
      mpie_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      kind_q   <= kind_d;
      pend_q   <= pend_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      cnt_q    <= cnt_d;
      mepc_q   <= mepc_d;
      mcause_q <= mcause_d;
      mtval_q  <= mtval_d;
      mie_q    <= mie_d;
      mpie_q   <= mpie_d;
    end
  end

  always_comb begin
    // Fetch is also frozen during the accept-to-FLUSH gap.
    STALL_o       = (state_q != S_IDLE) || pend_q;
    FLUSH_o       = (state_q == S_FLUSH);
    PC_REDIRECT_o = (state_q == S_REDIRECT);
    BUSY_o        = (state_q != S_IDLE);
  end

  always_comb begin
    PC_TARGET_o = BASE;
    if (kind_q == REQ_MRET) begin
      PC_TARGET_o = mepc_q;
    end
`ifdef TRAP_VECTORED_EN
    else if (kind_q == REQ_IRQ) begin
      PC_TARGET_o = BASE + {25'd0, mcause_q[4:0], 2'b00};
    end
`endif
  end

  assign MEPC_o   = mepc_q;
  assign MCAUSE_o = mcause_q;
  assign MTVAL_o  = mtval_q;
  assign MIE_o    = mie_q;

endmodule
`default_nettype wire

// File: tb/tb_trap_sequencer.sv
`default_nettype none
// Directed bench for trap_sequencer; expected redirect results are queued at drive time.
module tb_trap_sequencer;

  logic        CLK = 1'b0;
  logic        RSTn;
  logic        EN;
  logic        ILLEGAL_INSTR_i;
  logic        ECALL_i;
  logic        EXT_IRQ_i;
  logic        MRET_i;
  logic [31:0] TRAP_PC_i;
  logic [31:0] TRAP_INSTR_i;
  logic        FLUSH_ACK_i;
  logic        STALL_o;
  logic        FLUSH_o;
  logic        PC_REDIRECT_o;
  logic [31:0] PC_TARGET_o;
  logic [31:0] MEPC_o;
  logic [31:0] MCAUSE_o;
  logic [31:0] MTVAL_o;
  logic        MIE_o;
  logic        BUSY_o;

  always #5 CLK = ~CLK;

  trap_sequencer #(
    .MTVEC_BASE    (32'h0000_0100),
    .FLUSH_TIMEOUT (8)
  ) dut (
    .CLK             (CLK),
    .RSTn            (RSTn),
    .EN              (EN),
    .ILLEGAL_INSTR_i (ILLEGAL_INSTR_i),
    .ECALL_i         (ECALL_i),
    .EXT_IRQ_i       (EXT_IRQ_i),
    .MRET_i          (MRET_i),
    .TRAP_PC_i       (TRAP_PC_i),
    .TRAP_INSTR_i    (TRAP_INSTR_i),
    .FLUSH_ACK_i     (FLUSH_ACK_i),
    .STALL_o         (STALL_o),
    .FLUSH_o         (FLUSH_o),
    .PC_REDIRECT_o   (PC_REDIRECT_o),
    .PC_TARGET_o     (PC_TARGET_o),
    .MEPC_o          (MEPC_o),
    .MCAUSE_o        (MCAUSE_o),
    .MTVAL_o         (MTVAL_o),
    .MIE_o           (MIE_o),
    .BUSY_o          (BUSY_o)
  );

  typedef struct {
    string       tag;
    logic [31:0] target;
    logic [31:0] mepc;
    logic [31:0] mcause;
    logic [31:0] mtval;
    logic        mie;
    int          lat;
    int          fl;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad   = 0;
  logic        m_mie, m_mpie;
  logic [31:0] m_mepc, m_mcause, m_mtval;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model of the architectural effect of one accepted request.
  task automatic push(input string tag, input bit irq, input bit ill, input bit ec,
                      input logic [31:0] pc, input logic [31:0] instr, input int lat, input int fl);
    exp_t e;
    bit   take_irq;
    take_irq = irq && m_mie;
    e.tag = tag;
    e.lat = lat;
    e.fl  = fl;
    if (take_irq || ill || ec) begin
      m_mepc   = pc & 32'hFFFF_FFFC;
      m_mcause = take_irq ? 32'h8000_000B : (ill ? 32'd2 : 32'd11);
      m_mtval  = (!take_irq && ill) ? instr : 32'd0;
      m_mpie   = m_mie;
      m_mie    = 1'b0;
      e.target = 32'h0000_0100;
`ifdef TRAP_VECTORED_EN
      if (take_irq) e.target = 32'h0000_012C;
`endif
    end else begin
      m_mie    = m_mpie;
      m_mpie   = 1'b1;
      e.target = m_mepc;
    end
    e.mepc   = m_mepc;
    e.mcause = m_mcause;
    e.mtval  = m_mtval;
    e.mie    = m_mie;
    sb.push_back(e);
  endtask

  task automatic req(input string tag, input bit irq, input bit ill, input bit ec, input bit mr,
                     input logic [31:0] pc, input logic [31:0] instr, input bit ack);
    EXT_IRQ_i       = irq;
    ILLEGAL_INSTR_i = ill;
    ECALL_i         = ec;
    MRET_i          = mr;
    TRAP_PC_i       = pc;
    TRAP_INSTR_i    = instr;
    FLUSH_ACK_i     = ack;
    push(tag, irq, ill, ec, pc, instr, ack ? 4 : 11, ack ? 1 : 8);
  endtask

  task automatic wait_out(input bit drop_en, input bit settle);
    exp_t e;
    int   lat;
    int   fl;
    int   sbad;
    fl   = 0;
    sbad = 0;
    tick();
    lat = 1;
    ILLEGAL_INSTR_i = 1'b0;
    ECALL_i         = 1'b0;
    MRET_i          = 1'b0;
    if (drop_en) EN = 1'b0;
    while (PC_REDIRECT_o !== 1'b1 && lat < 60) begin
      if (FLUSH_o === 1'b1) fl++;
      if (BUSY_o === 1'b1 && STALL_o !== 1'b1) sbad++;
      tick();
      lat++;
    end
    chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    chk({e.tag, ".redirect"},     32'(PC_REDIRECT_o), 32'd1);
    chk({e.tag, ".latency"},      lat,         e.lat);
    chk({e.tag, ".flush_cycles"}, fl,          e.fl);
    chk({e.tag, ".stall_busy"},   sbad,        32'd0);
    chk({e.tag, ".stall_redir"},  32'(STALL_o), 32'd1);
    chk({e.tag, ".target"},       PC_TARGET_o, e.target);
    chk({e.tag, ".mepc"},         MEPC_o,      e.mepc);
    chk({e.tag, ".mcause"},       MCAUSE_o,    e.mcause);
    chk({e.tag, ".mtval"},        MTVAL_o,     e.mtval);
    chk({e.tag, ".mie"},          32'(MIE_o),  32'(e.mie));
    if (settle) begin
      tick();
      chk({e.tag, ".strobe_off"}, 32'(PC_REDIRECT_o), 32'd0);
      chk({e.tag, ".idle"},       32'(BUSY_o),        32'd0);
    end
  endtask

  initial begin
    int hits;
    RSTn = 1'b0; EN = 1'b1;
    ILLEGAL_INSTR_i = 1'b0; ECALL_i = 1'b0; EXT_IRQ_i = 1'b0; MRET_i = 1'b0;
    TRAP_PC_i = '0; TRAP_INSTR_i = '0; FLUSH_ACK_i = 1'b1;
    m_mie = 1'b0; m_mpie = 1'b0; m_mepc = '0; m_mcause = '0; m_mtval = '0;

    repeat (3) tick();
    chk("rst.stall",  32'(STALL_o),       32'd0);
    chk("rst.flush",  32'(FLUSH_o),       32'd0);
    chk("rst.redir",  32'(PC_REDIRECT_o), 32'd0);
    chk("rst.busy",   32'(BUSY_o),        32'd0);
    chk("rst.mie",    32'(MIE_o),         32'd0);
    chk("rst.target", PC_TARGET_o,        32'h0000_0100);
    chk("rst.mepc",   MEPC_o,             32'd0);
    chk("rst.mcause", MCAUSE_o,           32'd0);
    chk("rst.mtval",  MTVAL_o,            32'd0);
    RSTn = 1'b1;
    tick();

    req("ill_40", 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0040, 32'hFFFF_FFFF, 1'b1);
    wait_out(1'b0, 1'b1);

    // Interrupt masked while MIE=0: nothing may start.
    EXT_IRQ_i = 1'b1;
    hits = 0;
    repeat (4) begin
      tick();
      if (BUSY_o !== 1'b0 || STALL_o !== 1'b0) hits++;
    end
    chk("irq_masked.idle", hits, 32'd0);
    EXT_IRQ_i = 1'b0;

    req("prio_mie0", 1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0048, 32'h1234_5678, 1'b1);
    wait_out(1'b0, 1'b1);
    EXT_IRQ_i = 1'b0;

    req("ecall_timeout", 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0051, 32'h0000_0073, 1'b0);
    wait_out(1'b0, 1'b1);
    FLUSH_ACK_i = 1'b1;

    req("mret_a", 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0200, 32'h3020_0073, 1'b1);
    wait_out(1'b0, 1'b1);
    req("mret_b", 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0204, 32'h3020_0073, 1'b1);
    wait_out(1'b0, 1'b1);
    chk("mie_enabled", 32'(MIE_o), 32'd1);

    req("ill_44", 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0044, 32'hDEAD_BEEF, 1'b1);
    wait_out(1'b0, 1'b1);
    req("mret_44", 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0300, 32'h3020_0073, 1'b1);
    wait_out(1'b0, 1'b1);

    req("prio_mie1", 1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0060, 32'h0000_ABCD, 1'b1);
    wait_out(1'b0, 1'b1);
    EXT_IRQ_i = 1'b0;

    // MRET with the interrupt held: re-entry on the first IDLE cycle after REDIRECT.
    req("mret_irq", 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0070, 32'h0, 1'b1);
    push("irq_reentry", 1'b1, 1'b0, 1'b0, 32'h0000_0070, 32'h0, 5, 1);
    wait_out(1'b0, 1'b0);
    wait_out(1'b0, 1'b1);
    EXT_IRQ_i = 1'b0;

    EN = 1'b0;
    ECALL_i = 1'b1;
    hits = 0;
    repeat (3) begin
      tick();
      if (BUSY_o !== 1'b0) hits++;
    end
    chk("en_low.idle", hits, 32'd0);
    EN = 1'b1;
    req("ecall_en_drop", 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0080, 32'h0000_0073, 1'b1);
    wait_out(1'b1, 1'b1);
    EN = 1'b1;

    // Reset while flushing aborts the trap entirely.
    ILLEGAL_INSTR_i = 1'b1; TRAP_PC_i = 32'h0000_0090; FLUSH_ACK_i = 1'b0;
    tick();
    ILLEGAL_INSTR_i = 1'b0;
    tick();
    chk("abort.in_flush", 32'(FLUSH_o), 32'd1);
    RSTn = 1'b0;
    #1;
    chk("abort.busy",   32'(BUSY_o), 32'd0);
    chk("abort.mcause", MCAUSE_o,    32'd0);
    tick();
    RSTn = 1'b1;
    hits = 0;
    repeat (15) begin
      tick();
      if (PC_REDIRECT_o !== 1'b0 || BUSY_o !== 1'b0) hits++;
    end
    chk("abort.no_redirect", hits, 32'd0);
    chk("abort.mcause_kept", MCAUSE_o, 32'd0);
    chk("abort.mepc_kept",   MEPC_o,   32'd0);
    chk("abort.target",      PC_TARGET_o, 32'h0000_0100);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
